// File: rtl/mem_interface.sv
// mem_interface: data-memory slave for the multicycle CPU.
//
// Accepts rising edges of MemRd/MemWr (qualified by MemEnable), inserts WAIT_CYCLES wait
// states, then performs a word or byte access to an internal word-organised RAM. Each
// accepted request finishes with a one-cycle MemRdy pulse. Misaligned word accesses and
// simultaneous read/write edges finish with MemRdy plus AlignErr and no RAM access.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   MemEnable  in   qualifies MemRd/MemWr
//   MemRd      in   read strobe, rising edge starts a read
//   MemWr      in   write strobe, rising edge starts a write
//   MemLength  in   1 = 32-bit word, 0 = byte
//   Addr       in   byte address, low ADDR_W bits used
//   DataIn     in   write data, byte writes use DataIn[7:0]
//   DataOut    out  read data, held until the next completed read
//   MemRdy     out  one-cycle completion pulse
//   Busy       out  request in flight
//   AlignErr   out  one-cycle error pulse, coincident with MemRdy
module mem_interface #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemEnable,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        MemLength,
    input  logic [31:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MemRdy,
    output logic        Busy,
    output logic        AlignErr
);

    localparam int unsigned Depth = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_prev_q, wr_prev_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              word_q, word_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [31:0]       dout_q, dout_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              aerr_q, aerr_d;

    logic [31:0]       mem [Depth];

    logic              rd_req, wr_req, req;
    logic [ADDR_W-3:0] widx;
    logic [4:0]        shift;
    logic [31:0]       rword, wmask, wword;
    logic              ram_we;
    logic              unused_addr;

    // Address bits above ADDR_W are ignored, so addresses wrap.
    assign unused_addr = ^Addr[31:ADDR_W];

    assign rd_req = MemEnable & MemRd & ~rd_prev_q;
    assign wr_req = MemEnable & MemWr & ~wr_prev_q;
    assign req    = rd_req | wr_req;

    assign widx   = addr_q[ADDR_W-1:2];
    assign shift  = {addr_q[1:0], 3'b000};
    assign rword  = mem[widx];
    assign wmask  = word_q ? 32'hFFFF_FFFF : (32'h0000_00FF << shift);
    assign wword  = word_q ? wdata_q : ({24'b0, wdata_q[7:0]} << shift);
    assign ram_we = (state_q == StAccess) && write_q && !err_q;

    // RAM is not reset; the write only happens on the edge that ends ACCESS, so a reset
    // before that edge leaves memory untouched.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            mem[widx] <= (rword & ~wmask) | (wword & wmask);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            word_q    <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= 32'd0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            aerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_prev_q <= MemRd;
            wr_prev_q <= MemWr;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            word_q    <= word_d;
            write_q   <= write_d;
            err_q     <= err_d;
            dout_q    <= dout_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            aerr_q    <= aerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        write_d = write_q;
        err_d   = err_q;
        dout_d  = dout_q;
        rdy_d   = 1'b0;
        aerr_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = Addr[ADDR_W-1:0];
                    wdata_d = DataIn;
                    word_d  = MemLength;
                    write_d = wr_req;
                    err_d   = (rd_req & wr_req) | (MemLength & (Addr[1:0] != 2'b00));
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAccess: begin
                // Completion flags are registered, so they appear in the cycle after ACCESS.
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
                if (err_q) begin
                    aerr_d = 1'b1;
                end else if (!write_q) begin
                    dout_d = word_q ? rword : ((rword >> shift) & 32'h0000_00FF);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign DataOut  = dout_q;
    assign MemRdy   = rdy_q;
    assign Busy     = busy_q;
    assign AlignErr = aerr_q;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: one instance with two wait states, one with none.
module tb_mem_interface;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic        mem_rd = 1'b0, mem_wr = 1'b0, mem_len = 1'b0;
    logic [31:0] addr = 32'd0, din = 32'd0;
    logic [31:0] dout_a, dout_b;
    logic        rdy_a, rdy_b, busy_a, busy_b, aerr_a, aerr_b;

    int vectors = 0;
    int miscompares = 0;

    // Reference model of the two-wait-state instance: word array plus last read data.
    logic [31:0] ref_a [256];
    logic [31:0] exp_a = 32'd0;

    always #5 Clk = ~Clk;

    mem_interface #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .MemEnable(en_a), .MemRd(mem_rd), .MemWr(mem_wr),
        .MemLength(mem_len), .Addr(addr), .DataIn(din), .DataOut(dout_a),
        .MemRdy(rdy_a), .Busy(busy_a), .AlignErr(aerr_a)
    );

    mem_interface #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .MemEnable(en_b), .MemRd(mem_rd), .MemWr(mem_wr),
        .MemLength(mem_len), .Addr(addr), .DataIn(din), .DataOut(dout_b),
        .MemRdy(rdy_b), .Busy(busy_b), .AlignErr(aerr_b)
    );

    function automatic logic [31:0] byte_of(input logic [31:0] w, input logic [31:0] a);
        return (w >> (8 * (a % 4))) & 32'hFF;
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [31:0] a,
                                               input logic [31:0] d);
        logic [31:0] sh;
        sh = 8 * (a % 4);
        return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    endfunction

    // Applies one request to the model and yields the expected error flag and DataOut.
    function automatic void model_a(input bit rd, input bit wr, input bit len,
                                    input logic [31:0] a, input logic [31:0] d,
                                    output bit e_err, output logic [31:0] e_dout);
        int unsigned idx;
        idx   = (a % 1024) / 4;
        e_err = (rd && wr) || (len && (a % 4 != 0));
        if (!e_err) begin
            if (wr) ref_a[idx] = len ? d : merge_byte(ref_a[idx], a, d);
            else exp_a = len ? ref_a[idx] : byte_of(ref_a[idx], a);
        end
        e_dout = exp_a;
    endfunction

    // Issues one request to the selected instance (z=1: zero-wait) and reports how many
    // edges after acceptance MemRdy appeared, plus AlignErr and DataOut at that point.
    task automatic access(input bit z, input bit rd, input bit wr, input bit len,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output bit err, output logic [31:0] dout);
        lat  = -1;
        err  = 1'b0;
        dout = 32'hxxxx_xxxx;
        @(negedge Clk);
        en_a = ~z; en_b = z; mem_rd = rd; mem_wr = wr; mem_len = len; addr = a; din = d;
        @(posedge Clk);
        @(negedge Clk);
        en_a = 1'b0; en_b = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        addr = $urandom; din = $urandom; mem_len = 1'($urandom_range(0, 1));
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk);
            #1;
            if ((z ? rdy_b : rdy_a) === 1'b1) begin
                lat  = k;
                err  = z ? aerr_b : aerr_a;
                dout = z ? dout_b : dout_a;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        vectors++;
        if ({dout_a, rdy_a, busy_a, aerr_a} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_a: got dout=%h rdy=%b busy=%b aerr=%b, want all 0",
                     dout_a, rdy_a, busy_a, aerr_a);
        end
        vectors++;
        if ({dout_b, rdy_b, busy_b, aerr_b} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_b: got dout=%h rdy=%b busy=%b aerr=%b, want all 0",
                     dout_b, rdy_b, busy_b, aerr_b);
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_word_rw();
        int lat; bit err, e_err; logic [31:0] dout, e_dout, a, d;
        access(0, 0, 1, 1, 32'h10, 32'hDEADBEEF, lat, err, dout);
        model_a(0, 1, 1, 32'h10, 32'hDEADBEEF, e_err, e_dout);
        vectors++;
        if (lat !== 3 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL word_write: got lat=%0d err=%b, want lat=3 err=0", lat, err);
        end
        access(0, 1, 0, 1, 32'h10, 32'd0, lat, err, dout);
        model_a(1, 0, 1, 32'h10, 32'd0, e_err, e_dout);
        vectors++;
        if (lat !== 3 || err !== 1'b0 || dout !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL word_read: got lat=%0d err=%b dout=%h, want lat=3 err=0 dout=deadbeef",
                     lat, err, dout);
        end
        // Fill every word with random data, using random upper address bits.
        for (int i = 0; i < 256; i++) begin
            a = (i * 4) | ($urandom & 32'hFFFF_FC00);
            d = $urandom;
            access(0, 0, 1, 1, a, d, lat, err, dout);
            model_a(0, 1, 1, a, d, e_err, e_dout);
            vectors++;
            if (lat !== 3 || err !== e_err) begin
                miscompares++;
                $display("FAIL fill_write @%h: got lat=%0d err=%b, want lat=3 err=%b",
                         a, lat, err, e_err);
            end
        end
        for (int i = 0; i < 30; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            access(0, 1, 0, 1, a, 32'd0, lat, err, dout);
            model_a(1, 0, 1, a, 32'd0, e_err, e_dout);
            vectors++;
            if (lat !== 3 || err !== e_err || dout !== e_dout) begin
                miscompares++;
                $display("FAIL rand_word_read @%h: got lat=%0d err=%b dout=%h, want 3 %b %h",
                         a, lat, err, dout, e_err, e_dout);
            end
        end
    endtask

    task automatic test_byte_lanes();
        int lat; bit err, e_err, rd, len; logic [31:0] dout, e_dout, a, d;
        access(0, 0, 1, 1, 32'h10, 32'h11223344, lat, err, dout);
        model_a(0, 1, 1, 32'h10, 32'h11223344, e_err, e_dout);
        access(0, 0, 1, 0, 32'h13, 32'hFFFF_FF5A, lat, err, dout);
        model_a(0, 1, 0, 32'h13, 32'hFFFF_FF5A, e_err, e_dout);
        access(0, 1, 0, 1, 32'h10, 32'd0, lat, err, dout);
        model_a(1, 0, 1, 32'h10, 32'd0, e_err, e_dout);
        vectors++;
        if (lat !== 3 || dout !== 32'h5A223344) begin
            miscompares++;
            $display("FAIL byte_merge: got lat=%0d dout=%h, want lat=3 dout=5a223344", lat, dout);
        end
        access(0, 1, 0, 0, 32'h13, 32'd0, lat, err, dout);
        model_a(1, 0, 0, 32'h13, 32'd0, e_err, e_dout);
        vectors++;
        if (lat !== 3 || dout !== 32'h0000005A) begin
            miscompares++;
            $display("FAIL byte_read: got lat=%0d dout=%h, want lat=3 dout=0000005a", lat, dout);
        end
        for (int i = 0; i < 60; i++) begin
            rd  = 1'($urandom_range(0, 1));
            len = 1'($urandom_range(0, 1));
            a   = $urandom;
            if (len) a = a & 32'hFFFF_FFFC;
            d   = $urandom;
            access(0, rd, !rd, len, a, d, lat, err, dout);
            model_a(rd, !rd, len, a, d, e_err, e_dout);
            vectors++;
            if (lat !== 3 || err !== e_err || dout !== e_dout) begin
                miscompares++;
                $display("FAIL rand_op rd=%b len=%b @%h: got lat=%0d err=%b dout=%h, want 3 %b %h",
                         rd, len, a, lat, err, dout, e_err, e_dout);
            end
        end
    endtask

    task automatic test_misaligned();
        int lat; bit err, e_err; logic [31:0] dout, e_dout, held;
        held = exp_a;
        access(0, 1, 0, 1, 32'h22, 32'd0, lat, err, dout);
        model_a(1, 0, 1, 32'h22, 32'd0, e_err, e_dout);
        vectors++;
        if (lat !== 3 || err !== 1'b1 || dout !== held) begin
            miscompares++;
            $display("FAIL misaligned_read: got lat=%0d err=%b dout=%h, want lat=3 err=1 dout=%h",
                     lat, err, dout, held);
        end
        @(posedge Clk);
        #1;
        vectors++;
        if (aerr_a !== 1'b0 || rdy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse_width: got aerr=%b rdy=%b a cycle later, want 0 0",
                     aerr_a, rdy_a);
        end
        access(0, 0, 1, 1, 32'h21, ~ref_a[8], lat, err, dout);
        model_a(0, 1, 1, 32'h21, ~ref_a[8], e_err, e_dout);
        vectors++;
        if (lat !== 3 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL misaligned_write: got lat=%0d err=%b, want lat=3 err=1", lat, err);
        end
        access(0, 1, 1, 1, 32'h24, ~ref_a[9], lat, err, dout);
        model_a(1, 1, 1, 32'h24, ~ref_a[9], e_err, e_dout);
        vectors++;
        if (lat !== 3 || err !== 1'b1 || dout !== held) begin
            miscompares++;
            $display("FAIL rd_wr_both: got lat=%0d err=%b dout=%h, want lat=3 err=1 dout=%h",
                     lat, err, dout, held);
        end
        for (int i = 8; i < 10; i++) begin
            access(0, 1, 0, 1, i * 4, 32'd0, lat, err, dout);
            model_a(1, 0, 1, i * 4, 32'd0, e_err, e_dout);
            vectors++;
            if (err !== 1'b0 || dout !== e_dout) begin
                miscompares++;
                $display("FAIL ram_untouched word %0d: got err=%b dout=%h, want err=0 dout=%h",
                         i, err, dout, e_dout);
            end
        end
    endtask

    task automatic test_held_strobe();
        int pulses; bit e_err; logic [31:0] a, e_dout;
        pulses = 0;
        a = $urandom_range(0, 255) * 4;
        model_a(1, 0, 1, a, 32'd0, e_err, e_dout);
        @(negedge Clk);
        en_a = 1'b1; mem_rd = 1'b1; mem_len = 1'b1; addr = a;
        for (int k = 0; k < 12; k++) begin
            @(posedge Clk);
            #1;
            if (rdy_a === 1'b1) pulses++;
            if (k == 5) begin
                mem_rd = 1'b0;
                en_a = 1'b0;
            end
        end
        vectors++;
        if (pulses !== 1 || dout_a !== e_dout) begin
            miscompares++;
            $display("FAIL held_strobe: got pulses=%0d dout=%h, want pulses=1 dout=%h",
                     pulses, dout_a, e_dout);
        end
    endtask

    task automatic test_back_to_back();
        int pulses, lat; bit err, e_err; logic [31:0] a, b, dout, e_dout;
        pulses = 0;
        a = $urandom_range(0, 127) * 4;
        b = a + 32'h200;
        model_a(1, 0, 1, a, 32'd0, e_err, e_dout);
        @(negedge Clk);
        en_a = 1'b1; mem_rd = 1'b1; mem_len = 1'b1; addr = a;
        @(posedge Clk);
        @(negedge Clk);
        vectors++;
        if (busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_set: got busy=%b, want 1", busy_a);
        end
        mem_rd = 1'b0; mem_wr = 1'b1; addr = b; din = ~ref_a[b / 4];
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk);
            #1;
            if (rdy_a === 1'b1) pulses++;
        end
        @(negedge Clk);
        mem_wr = 1'b0; en_a = 1'b0;
        vectors++;
        if (pulses !== 1 || dout_a !== e_dout || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_while_busy: got pulses=%0d dout=%h busy=%b, want 1 %h 0",
                     pulses, dout_a, busy_a, e_dout);
        end
        access(0, 1, 0, 1, b, 32'd0, lat, err, dout);
        model_a(1, 0, 1, b, 32'd0, e_err, e_dout);
        vectors++;
        if (lat !== 3 || dout !== e_dout) begin
            miscompares++;
            $display("FAIL ignored_write: got lat=%0d dout=%h, want lat=3 dout=%h",
                     lat, dout, e_dout);
        end
    endtask

    task automatic test_reset_abort();
        int lat; bit err, e_err; logic [31:0] dout, e_dout, old;
        old = $urandom | 32'h1;
        access(0, 0, 1, 1, 32'h40, old, lat, err, dout);
        model_a(0, 1, 1, 32'h40, old, e_err, e_dout);
        access(0, 1, 0, 1, 32'h44, 32'd0, lat, err, dout);
        model_a(1, 0, 1, 32'h44, 32'd0, e_err, e_dout);
        @(negedge Clk);
        en_a = 1'b1; mem_wr = 1'b1; mem_len = 1'b1; addr = 32'h40; din = ~old;
        @(posedge Clk);
        @(negedge Clk);
        mem_wr = 1'b0; en_a = 1'b0;
        vectors++;
        if (busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy: got busy=%b, want 1", busy_a);
        end
        Reset = 1'b0;
        #1;
        exp_a = 32'd0;
        vectors++;
        if ({dout_a, rdy_a, busy_a, aerr_a} !== 35'd0) begin
            miscompares++;
            $display("FAIL abort_outputs: got dout=%h rdy=%b busy=%b aerr=%b, want all 0",
                     dout_a, rdy_a, busy_a, aerr_a);
        end
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        access(0, 1, 0, 1, 32'h40, 32'd0, lat, err, dout);
        model_a(1, 0, 1, 32'h40, 32'd0, e_err, e_dout);
        vectors++;
        if (lat !== 3 || dout !== old) begin
            miscompares++;
            $display("FAIL abort_no_write: got lat=%0d dout=%h, want lat=3 dout=%h",
                     lat, dout, old);
        end
    endtask

    task automatic test_zero_wait();
        int lat; bit err; logic [31:0] dout, v;
        v = $urandom;
        access(1, 0, 1, 1, 32'h408, v, lat, err, dout);
        vectors++;
        if (lat !== 1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL zw_write: got lat=%0d err=%b, want lat=1 err=0", lat, err);
        end
        access(1, 1, 0, 1, 32'h8, 32'd0, lat, err, dout);
        vectors++;
        if (lat !== 1 || err !== 1'b0 || dout !== v) begin
            miscompares++;
            $display("FAIL zw_wrap_read: got lat=%0d err=%b dout=%h, want lat=1 err=0 dout=%h",
                     lat, err, dout, v);
        end
        access(1, 1, 0, 0, 32'hFFFF_FC0B, 32'd0, lat, err, dout);
        vectors++;
        if (lat !== 1 || dout !== (v >> 24)) begin
            miscompares++;
            $display("FAIL zw_byte_read: got lat=%0d dout=%h, want lat=1 dout=%h",
                     lat, dout, v >> 24);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_misaligned();
        test_held_strobe();
        test_back_to_back();
        test_reset_abort();
        test_zero_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
